alu_seq_divider: RTL and testbench

//   Multi-cycle 16-bit unsigned restoring divider. Replaces the single-cycle
//   x / y DIVIDE path in front of the result mux.
//   It takes operands from the A/B input-register stage and returns the

---
 rtl/alu_seq_divider_pkg.sv | 12 +
 rtl/alu_defs.sv | 9 +
 rtl/alu_seq_divider_div_step.sv | 21 ++
 rtl/alu_seq_divider.sv | 97 +++++++++
 tb/tb_alu_seq_divider.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/alu_seq_divider_pkg.sv
// Types and defaults shared by the sequential divider and its iteration stage.
package alu_seq_divider_pkg;
`include "alu_defs.sv"

  typedef enum logic [1:0] {
    ST_IDLE = `ST_IDLE,
    ST_RUN  = `ST_RUN,
    ST_DONE = `ST_DONE
  } div_state_e;

  localparam int DEFAULT_WIDTH = 16;
endpackage

// File: rtl/alu_defs.sv
// Shared encodings for the ALU sequential divider: FSM state codes and the
// quotient returned on a zero divisor. Guarded so every user can include it.
`ifndef ALU_DEFS_SV
`define ALU_DEFS_SV
`define ST_IDLE       2'd0
`define ST_RUN        2'd1
`define ST_DONE       2'd2
`define DIV_ZERO_QUOT '1
`endif

// File: rtl/alu_seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);
  // One extra bit keeps the compare exact when r is close to 2^WIDTH.
  logic [WIDTH:0] r_shift;

  always_comb begin
    r_shift = {r, q_msb};
    q_bit   = (r_shift >= {1'b0, divisor});
    // The result is always below divisor, so WIDTH-bit wraparound is exact.
    r_next  = q_bit ? (r_shift[WIDTH-1:0] - divisor) : r_shift[WIDTH-1:0];
  end
endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake;
// one quotient bit per clock, MSB first.
`include "alu_defs.sv"

module alu_seq_divider
  import alu_seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] rem_reg, dvs_reg, shq_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             dbz_reg;
  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic             accept, last_step;

  assign accept    = start && (state_reg != ST_RUN);
  assign last_step = (count_reg == CW'(1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (rem_reg),
    .q_msb   (shq_reg[WIDTH-1]),
    .divisor (dvs_reg),
    .r_next  (step_r),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = (divisor == '0) ? ST_DONE : ST_RUN;
        else       state_next = ST_IDLE;
      end
      ST_RUN:  if (last_step) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // shq_reg starts as the dividend and fills with quotient bits from the right.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg     <= '0;
      rem_reg       <= '0;
      dvs_reg       <= '0;
      shq_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (accept) begin
      shq_reg   <= dividend;
      dvs_reg   <= divisor;
      rem_reg   <= '0;
      count_reg <= CW'(WIDTH);
      dbz_reg   <= 1'b0;
      if (divisor == '0) begin
        quotient_reg  <= `DIV_ZERO_QUOT;
        remainder_reg <= dividend;
        dbz_reg       <= 1'b1;
      end
    end else if (state_reg == ST_RUN) begin
      rem_reg   <= step_r;
      shq_reg   <= {shq_reg[WIDTH-2:0], step_q};
      count_reg <= count_reg - CW'(1);
      if (last_step) begin
        quotient_reg  <= {shq_reg[WIDTH-2:0], step_q};
        remainder_reg <= step_r;
      end
    end
  end

  assign busy        = (state_reg == ST_RUN);
  assign done        = (state_reg == ST_DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;
endmodule

// File: tb/tb_alu_seq_divider.sv
// Scoreboard bench for alu_seq_divider: directed divisions with hand-computed
// results, checked by a monitor that pops one expectation per done pulse.
module tb_alu_seq_divider;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   t1, t2;

  alu_seq_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_cnt = busy_cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse consumes exactly one expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dz);
        chk("done_cycle", cyc, e.at);
        $display("vector q=%0d r=%0d dz=%0d at cycle %0d", quotient, remainder, div_by_zero, cyc);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic [15:0] r, input logic dz);
    @(negedge clk);
    busy_cnt = 0;
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back('{q: q, r: r, dz: dz, at: cyc + 1 + (dz ? 0 : 16)});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", busy, dz ? 0 : 1);
    drain();
    chk("busy_cycles", busy_cnt, dz ? 0 : 16);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    reset = 1'b0;

    issue(16'd6, 16'd3, 16'd2, 16'd0, 1'b0);
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    issue(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0);
    issue(16'd5, 16'd9, 16'd0, 16'd5, 1'b0);
    issue(16'd65535, 16'd65535, 16'd1, 16'd0, 1'b0);
    issue(16'd0, 16'd5, 16'd0, 16'd0, 1'b0);
    issue(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
    issue(16'd77, 16'd10, 16'd7, 16'd7, 1'b0);

    // Second request while busy must be dropped.
    @(negedge clk);
    busy_cnt = 0;
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    sb.push_back('{q: 16'd10, r: 16'd0, dz: 1'b0, at: cyc + 17});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_busy", busy, 1);
    drain();
    chk("ignored_busy_cycles", busy_cnt, 16);

    // Reset mid-run aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; dividend = 16'd40000; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    @(negedge clk);
    reset = 1'b0;
    issue(16'd9, 16'd4, 16'd2, 16'd1, 1'b0);

    // start held high: new operands presented in the done cycle start at once.
    @(negedge clk);
    start = 1'b1; dividend = 16'd81; divisor = 16'd9;
    sb.push_back('{q: 16'd9, r: 16'd0, dz: 1'b0, at: cyc + 17});
    t1 = -1; t2 = -1;
    for (int i = 0; i < 40 && t1 < 0; i++) begin
      @(negedge clk);
      if (done) t1 = cyc;
    end
    dividend = 16'd17; divisor = 16'd5;
    sb.push_back('{q: 16'd3, r: 16'd2, dz: 1'b0, at: cyc + 17});
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      @(negedge clk);
      if (done) t2 = cyc;
    end
    chk("b2b_first_seen", (t1 >= 0) ? 1 : 0, 1);
    chk("b2b_gap", t2 - t1, 17);
    drain();

    repeat (3) @(negedge clk);
    chk("leftover_expectations", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
